key_debounce_multi: RTL and testbench
=====================================

Name: key_debounce_multi

Overview:
- Synthesizable N-channel mechanical key debouncer, successor to the single-key stimulus/filter pair in the key_stable project.
- Each channel synchronises a raw bouncy key input and filters it with a per-channel state machine.
- Each channel outputs a clean level plus one-cycle press, release and long-press event flags.
- Sits between board key pins and user logic (LED/counter demos, menu controllers); one instance serves a whole key bank.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1_000_000, clock cycles the input must stay stable before a change is accepted (20 ms at 50 MHz); must be >= 2.
- LONG_CYCLES, 50_000_000, clock cycles a key must stay debounced-pressed before long_flag fires (1 s at 50 MHz); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = key_in reads 0 when pressed (board default); 0 = pressed reads 1.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous reset, active-high.
- key_in  input  N_KEYS  raw asynchronous key pins.
- key_state  output  N_KEYS  debounced level, 1 = pressed regardless of ACTIVE_LOW.
- press_flag  output  N_KEYS  one-cycle pulse on accepted press.
- release_flag  output  N_KEYS  one-cycle pulse on accepted release.
- long_flag  output  N_KEYS  one-cycle pulse, at most once per press, after LONG_CYCLES held.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Sync: per channel, a 2-FF synchroniser (s1 -> s2) on key_in. p = s2 normalised so that 1 = pressed.
- Channels are fully independent; no shared counters.
- Per-channel FSM states and counters:
  - States: IDLE (released), FILT_DN, DOWN, FILT_UP.
  - Debounce counter: clog2(DEBOUNCE_CYCLES) bits.
  - Hold counter: clog2(LONG_CYCLES) bits.
- IDLE:
  - p=1 -> FILT_DN, cnt<=0.
- FILT_DN:
  - p=0 -> IDLE (bounce rejected, no flag).
  - Else if cnt==DEBOUNCE_CYCLES-1 -> DOWN; press_flag<=1 for one cycle; key_state<=1; hold<=0; long_done<=0.
  - Else cnt++.
- DOWN:
  - p=0 -> FILT_UP, cnt<=0.
  - Hold counter increments each cycle while in DOWN or FILT_UP. When hold==LONG_CYCLES-1 and long_done=0: long_flag<=1 for one cycle, long_done<=1. Hold saturates; never wraps.
- FILT_UP:
  - p=1 -> DOWN. No flag; hold counter keeps its value; long_done is kept.
  - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE; release_flag<=1 for one cycle; key_state<=0.
  - Else cnt++.
- Latency: with key_in stable pressed from the clock edge E0 that first samples it, press_flag is high in the cycle following edge E0+DEBOUNCE_CYCLES+2 (2 sync + 1 FSM entry + DEBOUNCE_CYCLES-1 count + 1 register). Release latency is identical.
- Any return of p to the prior level during filtering restarts filtering from zero on the next change. No partial credit is kept.
- press_flag and release_flag of one channel are never high in the same cycle.
- long_flag may coincide with no other flag of the same channel, except:
  - Required: long_flag can fire while in FILT_UP if the threshold is reached there.
  - If release is then accepted, release_flag still fires later.
- Reset (any time, including mid-filter or mid-hold):
  - s1/s2 <= released level (1 if ACTIVE_LOW, else 0).
  - State <= IDLE; counters <= 0; long_done <= 0.
  - key_state, press_flag, release_flag, long_flag <= 0.
  - If the key is physically held through reset, a fresh press is reported after the full press latency.
- All outputs are registered; no combinational path from key_in to any output.

Test Plan:
(Params N_KEYS=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=40, ACTIVE_LOW=1.)
- Clean press: key_in[0] 1->0, held 60 cycles. Expected: press_flag[0] one pulse at cycle 11 after the first sampling edge; key_state[0]=1; long_flag[0] single pulse 40 cycles after press_flag; channels 1-3 stay 0.
- Bounce rejection: key_in[1] toggles with random 1-7 cycle intervals for 50 toggles, then settles 0. Expected: no flags during bounce; exactly one press_flag[1] 11 cycles after settling; likewise exactly one release_flag on release bounce.
- Short tap: key_in[2] low for 20 cycles. Expected: press_flag and release_flag each fire once; long_flag[2] never fires.
- Glitch while held: key_in[0] pressed, then 5-cycle high glitch at hold=15. Expected: no release_flag; key_state stays 1; long_flag still fires once at hold=39.
- Simultaneous channels: all four keys pressed on the same edge, released at staggered times. Expected: four press_flag bits high in the same cycle; release flags independent and correct.
- Reset mid-filter and mid-hold: assert Rst for 1 cycle while ch0 is in FILT_DN and ch1 is in DOWN with keys held. Expected: all outputs 0 next cycle; fresh press_flag on both channels 11 cycles after Rst deasserts; no release_flag.

Source files
------------

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
// N-channel mechanical key debouncer. Each channel runs its own 2-FF
// synchroniser and a four-state filter FSM. It produces a clean level plus
// one-cycle press, release and long-press pulses.
// Channels share nothing except the clock and reset.
// Parameter constraints: DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES.
module key_debounce_multi #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_flag,
  output logic [N_KEYS-1:0] release_flag,
  output logic [N_KEYS-1:0] long_flag
);

  // Counter widths. DEBOUNCE_CYCLES >= 2 keeps CW at one bit or more.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);

  // Terminal counts and increments, all sized to their counters.
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 32'sd1);
  localparam logic [CW-1:0] CNT_STEP  = CW'(32'd1);
  localparam logic [HW-1:0] HOLD_STEP = HW'(32'd1);

  // Pin level of a key that is not pressed. The synchroniser resets to this
  // value, so a reset never looks like a press edge.
  localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // debounced released
    ST_FILT_DN = 2'd1,  // candidate press, waiting for stability
    ST_DOWN    = 2'd2,  // debounced pressed
    ST_FILT_UP = 2'd3   // candidate release, waiting for stability
  } state_t;

  logic [N_KEYS-1:0] s1_r;
  logic [N_KEYS-1:0] s2_r;
  logic [N_KEYS-1:0] p_s;

  // Two-flop synchroniser for the asynchronous key pins.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_r <= {N_KEYS{REL_LVL}};
      s2_r <= {N_KEYS{REL_LVL}};
    end else begin
      s1_r <= key_in;
      s2_r <= s1_r;
    end
  end

  // Normalise the synchronised level so that 1 always means pressed.
  assign p_s = (ACTIVE_LOW != 0) ? ~s2_r : s2_r;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [HW-1:0]   hold_r;
    logic            long_done_r;
    logic            key_state_r;
    logic            press_r;
    logic            release_r;
    logic            long_r;
    logic            hold_active_s;

    // The hold time keeps counting through a release candidate. A bounce
    // during a long hold therefore does not restart the long-press timer.
    assign hold_active_s = (state_r == ST_DOWN) || (state_r == ST_FILT_UP);

    // Per-channel filter FSM with hold timer and registered event pulses.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        state_r     <= ST_IDLE;
        cnt_r       <= '0;
        hold_r      <= '0;
        long_done_r <= 1'b0;
        key_state_r <= 1'b0;
        press_r     <= 1'b0;
        release_r   <= 1'b0;
        long_r      <= 1'b0;
      end else begin
        // Event flags are single-cycle pulses unless re-asserted below.
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;

        // Saturating hold timer. It fires long_flag at most once per press.
        if (hold_active_s) begin
          if (hold_r == HOLD_LAST) begin
            if (!long_done_r) begin
              long_r      <= 1'b1;
              long_done_r <= 1'b1;
            end else begin
              long_done_r <= 1'b1;
            end
          end else begin
            hold_r <= hold_r + HOLD_STEP;
          end
        end else begin
          hold_r <= hold_r;
        end

        case (state_r)
          ST_IDLE: begin
            if (p_s[g]) begin
              state_r <= ST_FILT_DN;
              cnt_r   <= '0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_FILT_DN: begin
            if (!p_s[g]) begin
              // Bounce: drop the candidate without crediting any count.
              state_r <= ST_IDLE;
            end else if (cnt_r == DB_LAST) begin
              state_r     <= ST_DOWN;
              press_r     <= 1'b1;
              key_state_r <= 1'b1;
              hold_r      <= '0;
              long_done_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_STEP;
            end
          end
          ST_DOWN: begin
            if (!p_s[g]) begin
              state_r <= ST_FILT_UP;
              cnt_r   <= '0;
            end else begin
              state_r <= ST_DOWN;
            end
          end
          ST_FILT_UP: begin
            if (p_s[g]) begin
              // Glitch while held: go back to DOWN and keep the hold progress.
              state_r <= ST_DOWN;
            end else if (cnt_r == DB_LAST) begin
              state_r     <= ST_IDLE;
              release_r   <= 1'b1;
              key_state_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_STEP;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end

    assign key_state[g]    = key_state_r;
    assign press_flag[g]   = press_r;
    assign release_flag[g] = release_r;
    assign long_flag[g]    = long_r;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed testbench for key_debounce_multi.
// Configuration: DEBOUNCE_CYCLES=8, LONG_CYCLES=40, active-low keys.
// If key_in changes at the falling edge where cyc == c, the press or release
// pulse is seen at the falling edge where cyc == c+11. A long pulse follows
// 40 cycles after its press pulse.
module tb_key_debounce_multi;

  localparam int NK = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state;
  logic [NK-1:0] press_flag;
  logic [NK-1:0] release_flag;
  logic [NK-1:0] long_flag;

  key_debounce_multi #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES(40),
    .ACTIVE_LOW(1)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .key_in(key_in),
    .key_state(key_state),
    .press_flag(press_flag),
    .release_flag(release_flag),
    .long_flag(long_flag)
  );

  // 10-unit clock period.
  always #5 Clk = ~Clk;

  // Count of rising edges seen so far.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Event monitor: counts each pulse and records the cycle where it was last seen.
  int press_cnt   [NK] = '{default: 0};
  int release_cnt [NK] = '{default: 0};
  int long_cnt    [NK] = '{default: 0};
  int press_cyc   [NK] = '{default: 0};
  int release_cyc [NK] = '{default: 0};
  int long_cyc    [NK] = '{default: 0};

  always @(negedge Clk) begin
    for (int i = 0; i < NK; i++) begin
      if (press_flag[i] === 1'b1) begin
        press_cnt[i] <= press_cnt[i] + 1;
        press_cyc[i] <= cyc;
      end
      if (release_flag[i] === 1'b1) begin
        release_cnt[i] <= release_cnt[i] + 1;
        release_cyc[i] <= cyc;
      end
      if (long_flag[i] === 1'b1) begin
        long_cnt[i] <= long_cnt[i] + 1;
        long_cyc[i] <= cyc;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge Clk);
  endtask

  // Safety net against a stuck simulation.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    int pc [NK];
    int rc [NK];
    int lc [NK];

    // ---------------- reset ----------------
    Rst    = 1'b1;
    key_in = 4'hF;
    tick(3);
    Rst = 1'b0;
    tick(1);
    check("reset key_state", key_state, 4'h0);
    check("reset press", press_flag, 4'h0);
    check("reset release", release_flag, 4'h0);
    check("reset long", long_flag, 4'h0);

    // ---------------- clean press on ch0 ----------------
    c0 = cyc;
    key_in[0] = 1'b0;
    wait_until(c0 + 10);
    check("ch0 not yet pressed", key_state, 4'h0);
    wait_until(c0 + 11);
    check("ch0 press pulse", press_flag, 4'b0001);
    check("ch0 key_state up", key_state, 4'b0001);
    wait_until(c0 + 51);
    check("ch0 long pulse", long_flag, 4'b0001);
    wait_until(c0 + 60);
    check("ch0 press count", press_cnt[0], 1);
    check("ch0 press cycle", press_cyc[0], c0 + 11);
    check("ch0 long count", long_cnt[0], 1);
    check("ch0 long cycle", long_cyc[0], c0 + 51);
    check("ch1-3 idle presses", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("ch0 held level", key_state, 4'b0001);
    c1 = cyc;
    key_in[0] = 1'b1;
    wait_until(c1 + 11);
    check("ch0 release pulse", release_flag, 4'b0001);
    tick(5);
    check("ch0 release count", release_cnt[0], 1);
    check("ch0 release cycle", release_cyc[0], c1 + 11);
    check("ch0 released level", key_state, 4'h0);
    check("ch0 long once", long_cnt[0], 1);

    // ---------------- bounce rejection on ch1 ----------------
    for (int t = 0; t < 50; t++) begin
      key_in[1] = ~key_in[1];
      tick(int'($urandom_range(7, 1)));
    end
    check("ch1 no press in bounce", press_cnt[1], 0);
    check("ch1 still released", key_state[1], 1'b0);
    c0 = cyc;
    key_in[1] = 1'b0;
    wait_until(c0 + 11);
    check("ch1 press after settle", press_flag[1], 1'b1);
    tick(4);
    check("ch1 single press", press_cnt[1], 1);
    for (int t = 0; t < 50; t++) begin
      key_in[1] = ~key_in[1];
      tick(int'($urandom_range(7, 1)));
    end
    check("ch1 no release in bounce", release_cnt[1], 0);
    check("ch1 still pressed", key_state[1], 1'b1);
    c1 = cyc;
    key_in[1] = 1'b1;
    wait_until(c1 + 11);
    check("ch1 release after settle", release_flag[1], 1'b1);
    tick(4);
    check("ch1 single release", release_cnt[1], 1);
    check("ch1 press unchanged", press_cnt[1], 1);
    tick(5);

    // ---------------- short tap on ch2 ----------------
    c0 = cyc;
    key_in[2] = 1'b0;
    tick(20);
    key_in[2] = 1'b1;
    wait_until(c0 + 80);
    check("ch2 press count", press_cnt[2], 1);
    check("ch2 press cycle", press_cyc[2], c0 + 11);
    check("ch2 release count", release_cnt[2], 1);
    check("ch2 release cycle", release_cyc[2], c0 + 31);
    check("ch2 no long", long_cnt[2], 0);

    // ---------------- glitch while held on ch0 ----------------
    rc[0] = release_cnt[0];
    lc[0] = long_cnt[0];
    c0 = cyc;
    key_in[0] = 1'b0;
    wait_until(c0 + 26);
    key_in[0] = 1'b1;
    wait_until(c0 + 31);
    key_in[0] = 1'b0;
    wait_until(c0 + 35);
    check("ch0 level through glitch", key_state[0], 1'b1);
    wait_until(c0 + 51);
    check("ch0 long after glitch", long_flag, 4'b0001);
    wait_until(c0 + 70);
    check("ch0 no release on glitch", release_cnt[0], rc[0]);
    check("ch0 held after glitch", key_state[0], 1'b1);
    check("ch0 long once glitch", long_cnt[0], lc[0] + 1);
    check("ch0 long cycle glitch", long_cyc[0], c0 + 51);
    key_in[0] = 1'b1;
    tick(15);
    check("ch0 release after glitch", release_cnt[0], rc[0] + 1);

    // ---------------- simultaneous channels ----------------
    for (int i = 0; i < NK; i++) begin
      pc[i] = press_cnt[i];
      rc[i] = release_cnt[i];
      lc[i] = long_cnt[i];
    end
    c0 = cyc;
    key_in = 4'h0;
    wait_until(c0 + 11);
    check("all press same cycle", press_flag, 4'hF);
    check("all pressed level", key_state, 4'hF);
    for (int i = 0; i < NK; i++) begin
      wait_until(c0 + 15 + 3 * i);
      key_in[i] = 1'b1;
    end
    wait_until(c0 + 60);
    for (int i = 0; i < NK; i++) begin
      check($sformatf("sim ch%0d press count", i), press_cnt[i], pc[i] + 1);
      check($sformatf("sim ch%0d release count", i), release_cnt[i], rc[i] + 1);
      check($sformatf("sim ch%0d release cycle", i), release_cyc[i], c0 + 26 + 3 * i);
      check($sformatf("sim ch%0d no long", i), long_cnt[i], lc[i]);
    end
    check("sim all released", key_state, 4'h0);

    // ---------------- reset mid-filter and mid-hold ----------------
    c0 = cyc;
    key_in[1] = 1'b0;
    wait_until(c0 + 20);
    check("rst ch1 held before", key_state, 4'b0010);
    for (int i = 0; i < NK; i++) begin
      pc[i] = press_cnt[i];
      rc[i] = release_cnt[i];
    end
    c1 = cyc;
    key_in[0] = 1'b0;
    wait_until(c1 + 5);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    check("rst key_state cleared", key_state, 4'h0);
    check("rst press cleared", press_flag, 4'h0);
    check("rst release cleared", release_flag, 4'h0);
    check("rst long cleared", long_flag, 4'h0);
    wait_until(c1 + 17);
    check("rst fresh press both", press_flag, 4'b0011);
    wait_until(c1 + 30);
    check("rst ch0 press count", press_cnt[0], pc[0] + 1);
    check("rst ch1 press count", press_cnt[1], pc[1] + 1);
    check("rst ch0 press cycle", press_cyc[0], c1 + 17);
    check("rst ch1 press cycle", press_cyc[1], c1 + 17);
    check("rst ch0 no release", release_cnt[0], rc[0]);
    check("rst ch1 no release", release_cnt[1], rc[1]);
    check("rst both held", key_state, 4'b0011);
    key_in = 4'hF;
    tick(20);
    check("final released", key_state, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
